// File: rtl/home_inventory_pkg.sv
// home_inventory_pkg: shared constants, capture state type and channel clamp helper
package home_inventory_pkg;

    localparam int ADC_SAMPLE_W   = 24;
    localparam int ADC_NUM_CH_MAX = 4;
    localparam int ADC_TP_BASE    = 'h1000;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } cap_state_e;

    // Zero channels means one; anything above the physical count is clamped
    function automatic logic [3:0] clamp_ch(input logic [3:0] n, input logic [3:0] max_ch);
        return (n == 4'd0) ? 4'd1 : (n > max_ch) ? max_ch : n;
    endfunction

endpackage

// File: rtl/home_inventory_sync2.sv
// home_inventory_sync2: two-flop synchronizer with configurable reset value
module home_inventory_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk_i) begin
        if (rst_i) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/home_inventory_adc_capture.sv
// home_inventory_adc_capture: SPI frame capture for the load-cell ADC; HOME_INVENTORY_ADC_TEST_PATTERN_EN substitutes a frame-counter pattern for adc_miso
module home_inventory_adc_capture
    import home_inventory_pkg::*;
#(
    parameter int NUM_CH_MAX = ADC_NUM_CH_MAX,
    parameter int SAMPLE_W   = ADC_SAMPLE_W,
    parameter int SCLK_DIV   = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable,
    input  logic        start,
    input  logic [3:0]  num_ch,
    input  logic        adc_drdy_n,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [31:0] sample_data,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(SAMPLE_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLE_W - 1);
    localparam logic [3:0]    MAX_CH   = 4'(NUM_CH_MAX);

    cap_state_e          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [3:0]          ch_q, ch_d;
    logic [3:0]          eff_q, eff_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                oneshot_q, oneshot_d;
    logic [7:0]          ovr_q, ovr_d;
    logic                valid_q, valid_d;
    logic [1:0]          sch_q, sch_d;
    logic [31:0]         sdata_q, sdata_d;
    logic                done_q, done_d;
    logic                drdy_s, drdy_prev_q, drdy_evt;
    logic                div_last, in_frame, abort, bit_in;
    logic [DW-1:0]       div_nxt;
    logic [SAMPLE_W-1:0] word;

    home_inventory_sync2 #(.RST_VAL(1'b1)) u_drdy_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (adc_drdy_n),
        .q_o   (drdy_s)
    );

`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
    logic [11:0]         seq_q, seq_d;
    logic [SAMPLE_W-1:0] pat;
    logic                unused_miso;
    assign unused_miso = adc_miso;
    assign pat    = SAMPLE_W'(ADC_TP_BASE) + SAMPLE_W'(seq_q);
    assign bit_in = pat[BIT_LAST - bit_q];
`else
    assign bit_in = adc_miso;
`endif

    assign drdy_evt = drdy_prev_q & ~drdy_s;
    assign div_last = div_q == DIV_LAST;
    assign div_nxt  = div_last ? '0 : div_q + 1'b1;
    assign in_frame = state_q inside {CS_SETUP, SHIFT, CS_HOLD};
    assign abort    = in_frame && !enable && !oneshot_q;
    assign word     = {shift_q[SAMPLE_W-2:0], bit_in};

    // Next-state, SPI pin and sample strobe logic; abort overrides everything in flight
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        ch_d      = ch_q;
        eff_d     = eff_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        oneshot_d = oneshot_q;
        ovr_d     = (drdy_evt && in_frame && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
        valid_d   = 1'b0;
        sch_d     = sch_q;
        sdata_d   = sdata_q;
        done_d    = 1'b0;
`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
        seq_d     = seq_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable || start) begin
                    state_d   = ARMED;
                    oneshot_d = start;
                end
            end
            ARMED: begin
                if (drdy_evt) begin
                    state_d = CS_SETUP;
                    eff_d   = clamp_ch(num_ch, MAX_CH);
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    ch_d    = '0;
                end else if (!enable && !oneshot_q) begin
                    state_d = IDLE;
                end
            end
            CS_SETUP: begin
                div_d   = div_nxt;
                state_d = div_last ? SHIFT : CS_SETUP;
            end
            SHIFT: begin
                div_d = div_nxt;
                if (div_last) begin
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        shift_d = word;
                        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            valid_d = 1'b1;
                            sch_d   = ch_q[1:0];
                            sdata_d = {{(32-SAMPLE_W){word[SAMPLE_W-1]}}, word};
                            ch_d    = ch_q + 4'd1;
                            state_d = (ch_q == eff_q - 4'd1) ? CS_HOLD : SHIFT;
                        end
                    end
                end
            end
            CS_HOLD: begin
                div_d = div_nxt;
                if (div_last) begin
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    oneshot_d = 1'b0;
                    state_d   = enable ? ARMED : IDLE;
`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
                    seq_d     = seq_q + 12'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            sch_d   = sch_q;
            sdata_d = sdata_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            ch_q        <= '0;
            eff_q       <= 4'd1;
            shift_q     <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            oneshot_q   <= 1'b0;
            ovr_q       <= '0;
            valid_q     <= 1'b0;
            sch_q       <= '0;
            sdata_q     <= '0;
            done_q      <= 1'b0;
            drdy_prev_q <= 1'b1;
`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
            seq_q       <= 12'd1;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            ch_q        <= ch_d;
            eff_q       <= eff_d;
            shift_q     <= shift_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            oneshot_q   <= oneshot_d;
            ovr_q       <= ovr_d;
            valid_q     <= valid_d;
            sch_q       <= sch_d;
            sdata_q     <= sdata_d;
            done_q      <= done_d;
            drdy_prev_q <= drdy_s;
`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign adc_sclk     = sclk_q;
    assign adc_cs_n     = cs_n_q;
    assign sample_valid = valid_q;
    assign sample_ch    = sch_q;
    assign sample_data  = sdata_q;
    assign frame_done   = done_q;
    assign busy         = state_q != IDLE;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_home_inventory_adc_capture.sv
// tb_home_inventory_adc_capture: directed scoreboard bench with an SPI ADC model
module tb_home_inventory_adc_capture;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, start = 1'b0, drdy_n = 1'b1, miso = 1'b0;
    logic [3:0]  num_ch = 4'd1;
    logic        sclk, cs_n, valid, fd, busy;
    logic [1:0]  sch;
    logic [31:0] sdata;
    logic [7:0]  ovr;

    logic        enable8 = 1'b0, drdy8_n = 1'b1, miso8 = 1'b0;
    logic [3:0]  num_ch8 = 4'd4;
    logic        sclk8, cs8_n, valid8, fd8, busy8;
    logic [1:0]  sch8;
    logic [31:0] sdata8;
    logic [7:0]  ovr8;

    logic [23:0] words [0:3];
    logic        tie_one = 1'b0;
    int          bidx = 0;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   n_samp = 0, n_frames = 0, cs_low = 0, n_falls = 0, seq = 1;
    int   n_samp8 = 0, n_frames8 = 0;
    logic sclk_prev = 1'b0;

    home_inventory_adc_capture #(.SCLK_DIV(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .start(start), .num_ch(num_ch),
        .adc_drdy_n(drdy_n), .adc_miso(miso), .adc_sclk(sclk), .adc_cs_n(cs_n),
        .sample_valid(valid), .sample_ch(sch), .sample_data(sdata), .frame_done(fd),
        .busy(busy), .overrun_cnt(ovr)
    );

    home_inventory_adc_capture #(.SCLK_DIV(8)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable8), .start(1'b0), .num_ch(num_ch8),
        .adc_drdy_n(drdy8_n), .adc_miso(miso8), .adc_sclk(sclk8), .adc_cs_n(cs8_n),
        .sample_valid(valid8), .sample_ch(sch8), .sample_data(sdata8), .frame_done(fd8),
        .busy(busy8), .overrun_cnt(ovr8)
    );

    always #5 clk = ~clk;

    // ADC model: presents the next bit on each rising SCLK, channel 0 MSB first
    always @(negedge cs_n or posedge sclk) begin
        if (!cs_n && sclk) begin
            miso = tie_one ? 1'b1 : (bidx < 96) ? words[bidx / 24][23 - (bidx % 24)] : 1'b0;
            bidx++;
        end else begin
            bidx = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [23:0] w);
`ifdef HOME_INVENTORY_ADC_TEST_PATTERN_EN
        return 32'h1000 + 32'(seq);
`else
        return {{8{w[23]}}, w};
`endif
    endfunction

    task automatic push(input logic [1:0] ch, input logic [23:0] w);
        sb.push_back('{ch, exp_data(w)});
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (valid) begin
            n_samp++;
            if (sb.size() == 0) chk("unexpected_valid", 32'(valid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("sample_ch", 32'(sch), 32'(e.ch));
                chk("sample_data", sdata, e.data);
            end
        end
        if (fd) begin
            n_frames++;
            seq++;
        end
        if (!cs_n) cs_low++;
        if (sclk_prev && !sclk) n_falls++;
        sclk_prev = sclk;
        if (valid8) n_samp8++;
        if (fd8) n_frames8++;
    endtask

    task automatic drdy_edge();
        drdy_n = 1'b0;
        repeat (3) tick();
        drdy_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && n_frames < target; i++) tick();
    endtask

    initial begin
        int f0, s0;
        words[0] = 24'h0; words[1] = 24'h0; words[2] = 24'h0; words[3] = 24'h0;
        repeat (3) tick();
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ch", 32'(sch), 32'd0);
        chk("rst_data", sdata, 32'd0);
        chk("rst_fd", 32'(fd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        tick();

        // single channel, negative sample, CS window length
        num_ch = 4'd1; words[0] = 24'h800001; enable = 1'b1;
        tick();
        push(2'd0, words[0]);
        f0 = n_frames; s0 = n_samp; cs_low = 0;
        drdy_edge();
        wait_frames(f0 + 1, 400);
        repeat (10) tick();
        chk("t1_frames", 32'(n_frames - f0), 32'd1);
        chk("t1_cs_low", 32'(cs_low), 32'd100);
        chk("t1_samples", 32'(n_samp - s0), 32'd1);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // four channels with boundary values, then num_ch 0 and 9
        num_ch = 4'd4;
        words[0] = 24'h000001; words[1] = 24'h7FFFFF; words[2] = 24'h800000; words[3] = 24'h123456;
        for (int c = 0; c < 4; c++) push(2'(c), words[c]);
        f0 = n_frames; s0 = n_samp;
        drdy_edge();
        wait_frames(f0 + 1, 600);
        chk("t2_samples4", 32'(n_samp - s0), 32'd4);
        num_ch = 4'd0;
        push(2'd0, words[0]);
        f0 = n_frames; s0 = n_samp;
        drdy_edge();
        wait_frames(f0 + 1, 400);
        chk("t2_samples0", 32'(n_samp - s0), 32'd1);
        num_ch = 4'd9;
        for (int c = 0; c < 4; c++) push(2'(c), words[c]);
        f0 = n_frames; s0 = n_samp;
        drdy_edge();
        wait_frames(f0 + 1, 600);
        chk("t2_samples9", 32'(n_samp - s0), 32'd4);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // overrun saturation on the slow instance
        enable8 = 1'b1;
        drdy8_n = 1'b0; repeat (3) tick();
        drdy8_n = 1'b1; repeat (3) tick();
        chk("t3_busy8", 32'(busy8), 32'd1);
        for (int i = 0; i < 300; i++) begin
            drdy8_n = 1'b0; tick();
            drdy8_n = 1'b1; tick();
        end
        for (int i = 0; i < 2000 && n_frames8 < 1; i++) tick();
        chk("t3_ovr", 32'(ovr8), 32'd255);
        chk("t3_frames8", 32'(n_frames8), 32'd1);
        chk("t3_samples8", 32'(n_samp8), 32'd4);
        enable8 = 1'b0;

        // abort after 30 bits of a two-channel frame
        num_ch = 4'd2; words[0] = 24'h0ABCDE; words[1] = 24'h555555;
        push(2'd0, words[0]);
        f0 = n_frames; s0 = n_samp; n_falls = 0;
        drdy_edge();
        for (int i = 0; i < 500 && n_falls < 30; i++) tick();
        enable = 1'b0;
        tick();
        chk("t4_cs_n", 32'(cs_n), 32'd1);
        chk("t4_sclk", 32'(sclk), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (40) tick();
        chk("t4_no_done", 32'(n_frames - f0), 32'd0);
        chk("t4_samples", 32'(n_samp - s0), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // one-shot start with enable low; second start and DRDY are ignored
        num_ch = 4'd1; words[0] = 24'h3C3C3C;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_armed", 32'(busy), 32'd1);
        repeat (5) tick();
        chk("t5_held", 32'(busy), 32'd1);
        push(2'd0, words[0]);
        f0 = n_frames; s0 = n_samp;
        drdy_edge();
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_frames(f0 + 1, 400);
        tick();
        chk("t5_idle", 32'(busy), 32'd0);
        drdy_edge();
        repeat (40) tick();
        chk("t5_frames", 32'(n_frames - f0), 32'd1);
        chk("t5_samples", 32'(n_samp - s0), 32'd1);
        chk("t5_busy_end", 32'(busy), 32'd0);

        // two frames with MISO stuck high
        tie_one = 1'b1; enable = 1'b1;
        f0 = n_frames;
        push(2'd0, 24'hFFFFFF);
        drdy_edge();
        wait_frames(f0 + 1, 400);
        push(2'd0, 24'hFFFFFF);
        drdy_edge();
        wait_frames(f0 + 2, 400);
        chk("t6_frames", 32'(n_frames - f0), 32'd2);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        // reset in the middle of a frame
        drdy_edge();
        repeat (20) tick();
        chk("t7_midframe_cs", 32'(cs_n), 32'd0);
        rst = 1'b1;
        tick();
        chk("t7_rst_cs_n", 32'(cs_n), 32'd1);
        chk("t7_rst_sclk", 32'(sclk), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_data", sdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
